// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Frequency-sweep controller for a DDS. It steps a phase increment from
// f_start towards f_stop in f_step increments, holding each increment for
// max(dwell,1) cycles, and accumulates a reset-to-zero phase word that
// drives the DDS.
//
// Optional feature (macro SWEEP_PINGPONG_EN): once the up-sweep ends, the
// controller walks the increment back down to f_start (RET state) before
// finishing. The top step is not repeated on the way down.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        sweep request pulse, honoured only in IDLE
//   abort        terminate sweep, honoured in any non-IDLE state
//   f_start      first phase increment
//   f_stop       last (maximum) phase increment
//   f_step       increment step
//   dwell        cycles per frequency step (0 behaves as 1)
//   phase        phase word for the DDS
//   incr         current phase increment
//   phase_valid  phase is a live sweep sample
//   busy         high in every state other than IDLE
//   done         single-cycle pulse on normal sweep completion
//   err          single-cycle pulse on a rejected configuration
//   state_dbg    current FSM state encoding
//
// Handshake: start is a level sampled on a rising edge while IDLE; there is
// no ready/ack, busy reports whether a request will be ignored.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         f_start,
    input  logic [7:0]         f_stop,
    input  logic [7:0]         f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [7:0]         phase,
    output logic [7:0]         incr,
    output logic               phase_valid,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
`ifdef SWEEP_PINGPONG_EN
        S_RET  = 3'd4,
`endif
        S_DONE = 3'd3
    } state_t;

    state_t             state, state_nxt;
    logic [7:0]         f_start_r, f_stop_r, f_step_r;
    logic [7:0]         f_start_nxt, f_stop_nxt, f_step_nxt;
    logic [DWELL_W-1:0] dwell_r, dwell_nxt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt;
    logic [7:0]         phase_nxt, incr_nxt;
    logic               phase_valid_nxt, busy_nxt, done_nxt, err_nxt;

    logic               cfg_bad;
    logic [DWELL_W-1:0] dwell_load;
    logic [8:0]         phase_lim;
    logic [7:0]         phase_adv;
    logic               step_end;
    logic [8:0]         up_sum;
    logic               up_last;
`ifdef SWEEP_PINGPONG_EN
    logic signed [8:0]  dn_diff;
    logic               dn_last;
`endif

    assign state_dbg = state;

    always_comb begin
        // Configuration is judged on the live inputs at the moment start is taken.
        cfg_bad    = (f_step == 8'd0) || (f_start == 8'd0) || (f_start > f_stop);
        dwell_load = (dwell_r == '0) ? '0 : dwell_r - DWELL_W'(1);
        // Phase resets to zero instead of wrapping once it would reach 256.
        phase_lim  = 9'd256 - {1'b0, incr};
        phase_adv  = ({1'b0, phase} < phase_lim) ? phase + incr : 8'd0;
        step_end   = (dwell_cnt == '0);
        up_sum     = {1'b0, incr} + {1'b0, f_step_r};
        up_last    = (incr == f_stop_r) || (up_sum > {1'b0, f_stop_r});
`ifdef SWEEP_PINGPONG_EN
        dn_diff    = $signed({1'b0, incr}) - $signed({1'b0, f_step_r});
        dn_last    = (incr == f_start_r) || (dn_diff < $signed({1'b0, f_start_r}));
`endif

        state_nxt       = state;
        f_start_nxt     = f_start_r;
        f_stop_nxt      = f_stop_r;
        f_step_nxt      = f_step_r;
        dwell_nxt       = dwell_r;
        dwell_cnt_nxt   = dwell_cnt;
        phase_nxt       = phase;
        incr_nxt        = incr;
        phase_valid_nxt = phase_valid;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        err_nxt         = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    f_start_nxt = f_start;
                    f_stop_nxt  = f_stop;
                    f_step_nxt  = f_step;
                    dwell_nxt   = dwell;
                    if (cfg_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = S_LOAD;
                        busy_nxt  = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                incr_nxt        = f_start_r;
                phase_nxt       = 8'd0;
                dwell_cnt_nxt   = dwell_load;
                phase_valid_nxt = 1'b1;
                state_nxt       = S_RUN;
            end
            S_RUN: begin
                phase_nxt = phase_adv;
                if (!step_end) begin
                    dwell_cnt_nxt = dwell_cnt - DWELL_W'(1);
                end else if (!up_last) begin
                    incr_nxt      = up_sum[7:0];
                    dwell_cnt_nxt = dwell_load;
                end else begin
`ifdef SWEEP_PINGPONG_EN
                    // Step straight to the first lower increment so the top
                    // step is not played twice.
                    if (dn_last) begin
                        state_nxt       = S_DONE;
                        phase_valid_nxt = 1'b0;
                        done_nxt        = 1'b1;
                    end else begin
                        state_nxt     = S_RET;
                        incr_nxt      = dn_diff[7:0];
                        dwell_cnt_nxt = dwell_load;
                    end
`else
                    state_nxt       = S_DONE;
                    phase_valid_nxt = 1'b0;
                    done_nxt        = 1'b1;
`endif
                end
            end
`ifdef SWEEP_PINGPONG_EN
            S_RET: begin
                phase_nxt = phase_adv;
                if (!step_end) begin
                    dwell_cnt_nxt = dwell_cnt - DWELL_W'(1);
                end else if (!dn_last) begin
                    incr_nxt      = dn_diff[7:0];
                    dwell_cnt_nxt = dwell_load;
                end else begin
                    state_nxt       = S_DONE;
                    phase_valid_nxt = 1'b0;
                    done_nxt        = 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_nxt       = S_IDLE;
                busy_nxt        = 1'b0;
                phase_valid_nxt = 1'b0;
            end
            default: begin
                state_nxt       = S_IDLE;
                busy_nxt        = 1'b0;
                phase_valid_nxt = 1'b0;
            end
        endcase

        // Abort wins over everything outside IDLE, including a pending done.
        if (abort && (state != S_IDLE)) begin
            state_nxt       = S_IDLE;
            phase_nxt       = 8'd0;
            phase_valid_nxt = 1'b0;
            busy_nxt        = 1'b0;
            done_nxt        = 1'b0;
            err_nxt         = 1'b0;
            dwell_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            f_start_r   <= 8'd0;
            f_stop_r    <= 8'd0;
            f_step_r    <= 8'd0;
            dwell_r     <= '0;
            dwell_cnt   <= '0;
            phase       <= 8'd0;
            incr        <= 8'd0;
            phase_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            f_start_r   <= f_start_nxt;
            f_stop_r    <= f_stop_nxt;
            f_step_r    <= f_step_nxt;
            dwell_r     <= dwell_nxt;
            dwell_cnt   <= dwell_cnt_nxt;
            phase       <= phase_nxt;
            incr        <= incr_nxt;
            phase_valid <= phase_valid_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//
// Directed bench for dds_sweep_ctrl. A small reference model expands each
// sweep configuration into the expected {phase, incr} sample stream, which
// is queued before start is driven and popped for every cycle the DUT
// reports phase_valid.
// ---------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [7:0]         f_start, f_stop, f_step;
    logic [DWELL_W-1:0] dwell;
    logic [7:0]         phase, incr;
    logic               phase_valid, busy, done, err;
    logic [2:0]         state_dbg;

    logic [15:0] exp_q[$];
    logic [7:0]  exp_done_phase;
    logic [7:0]  exp_done_incr;
    int          exp_samples;
    int          total = 0;
    int          bad   = 0;

    dds_sweep_ctrl #(.DWELL_W(DWELL_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .f_start     (f_start),
        .f_stop      (f_stop),
        .f_step      (f_step),
        .dwell       (dwell),
        .phase       (phase),
        .incr        (incr),
        .phase_valid (phase_valid),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic build_model(input int fs, input int fe, input int st, input int dw);
        int incr_list[$];
        int v;
        int p;
        int reps;
        v = fs;
        forever begin
            incr_list.push_back(v);
            if (v == fe || v + st > fe) break;
            v = v + st;
        end
`ifdef SWEEP_PINGPONG_EN
        while (v != fs && v - st >= fs) begin
            v = v - st;
            incr_list.push_back(v);
        end
`endif
        reps = (dw == 0) ? 1 : dw;
        p = 0;
        exp_q.delete();
        foreach (incr_list[i]) begin
            for (int r = 0; r < reps; r++) begin
                exp_q.push_back({p[7:0], incr_list[i][7:0]});
                p = (p + incr_list[i] < 256) ? p + incr_list[i] : 0;
            end
        end
        exp_done_phase = p[7:0];
        exp_done_incr  = incr_list[incr_list.size()-1][7:0];
        exp_samples    = exp_q.size();
    endtask

    // ---------------- drivers ----------------
    task automatic drive_start(input logic [7:0] fs, input logic [7:0] fe,
                               input logic [7:0] st, input logic [DWELL_W-1:0] dw);
        @(posedge clk); #1;
        start = 1'b1; f_start = fs; f_stop = fe; f_step = st; dwell = dw;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the configuration to show the sweep uses its own copy.
        f_start = 8'($urandom_range(0, 255));
        f_stop  = 8'($urandom_range(0, 255));
        f_step  = 8'($urandom_range(0, 255));
        dwell   = DWELL_W'($urandom_range(0, 65535));
    endtask

    task automatic run_sweep(input logic [7:0] fs, input logic [7:0] fe,
                             input logic [7:0] st, input logic [DWELL_W-1:0] dw,
                             input string tag);
        int n;
        int guard;
        logic [15:0] e;
        build_model(fs, fe, st, dw);
        drive_start(fs, fe, st, dw);
        @(negedge clk);
        chk({tag, "_load_busy"}, busy, 1);
        chk({tag, "_load_pv"}, phase_valid, 0);
        n = 1;
        guard = 0;
        @(negedge clk);
        n++;
        while (phase_valid === 1'b1 && guard < 4000) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_extra_sample"}, 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_sample"}, {phase, incr}, e);
            end
            @(negedge clk);
            n++;
            guard++;
        end
        chk({tag, "_timeout"}, (guard >= 4000), 0);
        chk({tag, "_done_cycle"}, n, exp_samples + 2);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_busy"}, busy, 1);
        chk({tag, "_done_phase"}, phase, exp_done_phase);
        chk({tag, "_done_incr"}, incr, exp_done_incr);
        chk({tag, "_left"}, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_state"}, state_dbg, 0);
    endtask

    task automatic cfg_err(input logic [7:0] fs, input logic [7:0] fe,
                           input logic [7:0] st, input string tag);
        drive_start(fs, fe, st, 16'd3);
        @(negedge clk);
        chk({tag, "_err"}, err, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pv"}, phase_valid, 0);
        @(negedge clk);
        chk({tag, "_err_clr"}, err, 0);
        chk({tag, "_busy2"}, busy, 0);
        chk({tag, "_pv2"}, phase_valid, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] e;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        f_start = 8'd0; f_stop = 8'd0; f_step = 8'd0; dwell = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_phase", phase, 0);
        chk("rst_incr", incr, 0);
        chk("rst_pv", phase_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // Up-sweep 1,2,3 with four cycles per step.
        run_sweep(8'd1, 8'd3, 8'd1, 16'd4, "r031");
        // Single held increment of 64: 0,64,128,192,0.
        run_sweep(8'd64, 8'd64, 8'd1, 16'd5, "r032");
        // Stepping by two with single-cycle dwell.
        run_sweep(8'd2, 8'd6, 8'd2, 16'd1, "r033");
        // Top of range: 9-bit compare on 250+50, dwell 0 behaves as 1.
        run_sweep(8'd200, 8'd255, 8'd50, 16'd0, "edge");

        // Rejected configurations.
        cfg_err(8'd1, 8'd5, 8'd0, "step0");
        cfg_err(8'd9, 8'd5, 8'd1, "rev");
        cfg_err(8'd0, 8'd5, 8'd1, "start0");

        // start and abort together in IDLE: nothing starts.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        f_start = 8'd1; f_stop = 8'd3; f_step = 8'd1; dwell = 16'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("sa_busy", busy, 0);
        chk("sa_err", err, 0);
        @(negedge clk);
        chk("sa_busy2", busy, 0);
        chk("sa_pv", phase_valid, 0);

        // Abort in the third RUN cycle.
        build_model(1, 3, 1, 4);
        drive_start(8'd1, 8'd3, 8'd1, 16'd4);
        @(negedge clk);
        chk("ab_load_busy", busy, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk("ab_sample", {phase, incr}, e);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_pv", phase_valid, 0);
        chk("ab_phase", phase, 0);
        chk("ab_done", done, 0);
        chk("ab_state", state_dbg, 0);
        @(negedge clk);
        chk("ab_done2", done, 0);
        chk("ab_busy2", busy, 0);
        exp_q.delete();

        // Reset mid-sweep.
        build_model(1, 3, 1, 4);
        drive_start(8'd1, 8'd3, 8'd1, 16'd4);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk("mr_sample", {phase, incr}, e);
        end
        rst_n = 1'b0;
        #1;
        chk("mr_phase", phase, 0);
        chk("mr_incr", incr, 0);
        chk("mr_pv", phase_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mr_idle_busy", busy, 0);
            chk("mr_idle_done", done, 0);
        end
        run_sweep(8'd3, 8'd9, 8'd3, 16'd2, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
